sram: RTL and testbench
=======================

SRAM -- requirements
Module: sram

Interface
REQ-001 SHALL take parameter ADDR_W, default 18: address width in bits.
REQ-002 SHALL take parameter DATA_W, default 16: data word width in bits.
REQ-003 SHALL take parameter WR_LAT, default 2: clock cycles from write-access start to memory commit (legal range 1..15).
REQ-004 SHALL take parameter RD_LAT, default 2: clock cycles from read-access start to valid data_out (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port cs_n, input, 1 bit: chip select, active-low.
REQ-008 SHALL have port wr_n, input, 1 bit: write enable, active-low.
REQ-009 SHALL have port rd_n, input, 1 bit: read enable, active-low.
REQ-010 SHALL have port addr, input, ADDR_W bits: word address.
REQ-011 SHALL have port data_in, input, DATA_W bits: write data.
REQ-012 SHALL have port data_out, output, DATA_W bits: read data.
REQ-013 SHALL have port rd_valid, output, 1 bit: high while data_out holds valid read data.

Function
REQ-014 SHALL hold storage as an array named mem in the top module: 2**ADDR_W words of DATA_W bits, hierarchically readable by benches. Contents are uninitialised (X in simulation).
REQ-015 SHALL use three states: IDLE, WRITE and READ.
- IDLE: a rising edge with cs_n=0 and wr_n=0 captures addr and data_in, then enters WRITE.
- IDLE: otherwise, a rising edge with cs_n=0 and rd_n=0 captures addr, then enters READ.
REQ-016 SHALL write mem[captured addr] with the captured data exactly WR_LAT edges after the capture edge; mem SHALL be unchanged before that edge.
REQ-017 SHALL perform one write per access: after commit, stay in WRITE and do no further writes until cs_n or wr_n is high at an edge, then return to IDLE.
REQ-018 SHALL, in READ, assert rd_valid and drive mem[captured addr] on data_out from the RD_LAT-th edge after capture; this holds while cs_n=0 and rd_n=0.
REQ-019 SHALL, when cs_n or rd_n is high at an edge in READ, return to IDLE with rd_valid=0 and data_out invalid after that edge.
REQ-020 SHALL, when rd_valid=0, drive data_out with the invalid pattern defined in the Configuration section.
REQ-021 SHALL give write priority: with wr_n=0 and rd_n=0 together, perform a write and never assert rd_valid.
REQ-022 SHALL abort on cs_n or wr_n going high before commit: the write is not committed, mem is unchanged, and the state returns to IDLE.
REQ-023 SHALL ignore changes to addr or data_in after the capture edge for the rest of the access.
REQ-024 SHALL not wrap or truncate addresses: the full ADDR_W range is addressable, and the top address 2**ADDR_W-1 behaves like any other address.
REQ-025 SHALL make a read of a word whose write committed earlier return the new data; a read never bypasses an uncommitted write.

Reset
REQ-026 SHALL, while rst_n=0, immediately set state=IDLE, latency counter=0, rd_valid=0 and data_out to the invalid pattern.
REQ-027 SHALL not clear mem on reset; a write in flight when reset asserts is discarded with mem unchanged.

Configuration
REQ-028 SHALL, with SRAM_X_PROP_EN defined, use all-X as the invalid data_out pattern (simulation X-propagation).
REQ-029 SHALL, without SRAM_X_PROP_EN, use all-zero as the invalid data_out pattern (synthesis-safe).

Structure
REQ-030 SHALL place the ADDR_W, DATA_W, WR_LAT and RD_LAT default constants and the IDLE/WRITE/READ state typedef in package sram_pkg.
REQ-031 SHALL use no sub-module, so that mem stays directly in the top-level scope; the latency counter is an inline 4-bit counter.

Verification
REQ-032 SHALL verify a write and check its timing.
- Stimulus: cs_n=0, wr_n=0, addr=100, data_in=0x1234 at edge 0 (mem[100] previously unwritten).
- Required: mem[100] is X after edge 1 and 0x1234 after edge 2.
REQ-033 SHALL verify a read and check its timing.
- Stimulus: after REQ-032, hold cs_n and wr_n high for 10 cycles, then cs_n=0, rd_n=0, addr=100.
- Required with SRAM_X_PROP_EN: data_out is X and rd_valid=0 after edge 1; data_out=0x1234 and rd_valid=1 after edge 2.
REQ-034 SHALL verify write abort.
- Stimulus: start a write of 0xBEEF to addr 5, raise wr_n after 1 edge.
- Required: mem[5] unchanged and state=IDLE.
REQ-035 SHALL verify simultaneous read and write.
- Stimulus: wr_n=0, rd_n=0, addr=7, data_in=0x00A5.
- Required: mem[7]=0x00A5 after 2 edges; rd_valid stays 0 throughout.
REQ-036 SHALL verify reset mid-write.
- Stimulus: assert rst_n=0 one cycle into a write of 0x5555 to addr 0x3FFFF.
- Required: mem[0x3FFFF] unchanged, rd_valid=0 and state=IDLE immediately, with no clock edge needed.
REQ-037 SHALL verify the zero invalid pattern.
- Stimulus: build without SRAM_X_PROP_EN, then read any address.
- Required: data_out=0x0000 until the RD_LAT-th edge.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - default geometry/latency constants and FSM state type for sram
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_WR_LAT = 2;
  localparam int SRAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } sram_state_t;

endpackage

// File: rtl/sram.sv
// rtl/sram.sv - latency-modelled single-port SRAM; define SRAM_X_PROP_EN for an all-X invalid data_out pattern
module sram
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int WR_LAT = SRAM_WR_LAT,
  parameter int RD_LAT = SRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

`ifdef SRAM_X_PROP_EN
  localparam logic [DATA_W-1:0] INVALID = {DATA_W{1'bx}};
`else
  localparam logic [DATA_W-1:0] INVALID = '0;
`endif

  // Counter counts edges since the capture edge and saturates at the latency,
  // so "counter == latency" also means "write already committed / data valid".
  localparam logic [3:0] WR_DONE = 4'(WR_LAT);
  localparam logic [3:0] WR_LAST = 4'(WR_LAT - 1);
  localparam logic [3:0] RD_DONE = 4'(RD_LAT);
  localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  sram_state_t       r_state;
  sram_state_t       w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              r_rd_valid;
  logic              w_rd_valid_nxt;
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] w_data_out_nxt;
  logic              w_mem_we;
  logic              w_sel_wr;
  logic              w_sel_rd;

  assign w_sel_wr = !cs_n && !wr_n;
  assign w_sel_rd = !cs_n && !rd_n;

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;

  // Next-state, capture, latency counting and commit/valid decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rd_valid_nxt = 1'b0;
    w_data_out_nxt = INVALID;
    w_mem_we       = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Write wins when both strobes are low.
        if (w_sel_wr) begin
          w_state_nxt = WRITE;
          w_addr_nxt  = addr;
          w_wdata_nxt = data_in;
          w_cnt_nxt   = 4'd0;
        end else if (w_sel_rd) begin
          w_state_nxt = READ;
          w_addr_nxt  = addr;
          w_cnt_nxt   = 4'd0;
        end
      end
      WRITE: begin
        // Dropping the strobe before commit aborts; after commit it just ends the access.
        if (!w_sel_wr) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != WR_DONE) begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_mem_we  = (r_cnt == WR_LAST);
        end
      end
      READ: begin
        if (!w_sel_rd) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          if (r_cnt != RD_DONE) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
          if (r_cnt >= RD_LAST) begin
            w_rd_valid_nxt = 1'b1;
            w_data_out_nxt = mem[r_addr];
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Control and read-path registers; reset returns to IDLE with data_out invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_data_out <= INVALID;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  // Storage is never reset; the commit strobe is derived from r_state, which
  // reset forces to IDLE, so an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[r_addr] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_sram.sv
// tb/tb_sram.sv - self-checking bench for sram (default build, zero invalid pattern)
module tb_sram;
  import sram_pkg::*;

  localparam int ADDR_W = SRAM_ADDR_W;
  localparam int DATA_W = SRAM_DATA_W;
  localparam int WR_LAT = SRAM_WR_LAT;
  localparam int RD_LAT = SRAM_RD_LAT;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs_n = 1'b1;
  logic              wr_n = 1'b1;
  logic              rd_n = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;

  int checks = 0;
  int errors = 0;

  // Committed memory contents as implied by the access rules.
  logic [DATA_W-1:0] model [logic [ADDR_W-1:0]];

  sram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WR_LAT(WR_LAT),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .rd_n    (rd_n),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    cs_n = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
    repeat (n) tick();
  endtask

  // Stimulus only: a full-length committed write, recorded in the model.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = a; data_in = d;
    tick();
    repeat (WR_LAT) tick();
    go_idle(1);
    model[a] = d;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h want 0000", data_out); end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.r_state); end
    checks++;
    if (dut.r_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.r_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_timing();
    logic [DATA_W-1:0] old;
    old = dut.mem[100];
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = 100; data_in = 16'h1234;
    tick();
    addr = 101; data_in = 16'hFFFF;
    for (int k = 1; k <= WR_LAT + 1; k++) begin
      tick();
      checks++;
      if (k < WR_LAT) begin
        if (dut.mem[100] !== old) begin errors++; $display("FAIL write_early edge%0d got %h want %h", k, dut.mem[100], old); end
      end else begin
        if (dut.mem[100] !== 16'h1234) begin errors++; $display("FAIL write_commit edge%0d got %h want 1234", k, dut.mem[100]); end
      end
    end
    model[100] = 16'h1234;
    go_idle(1);
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL write_end_state got %0d want IDLE", dut.r_state); end
  endtask

  task automatic test_read_timing();
    logic [DATA_W-1:0] exp_d;
    go_idle(10);
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = 100;
    tick();
    addr = 5;
    checks++;
    if (rd_valid !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL read_capture got v=%b d=%h want v=0 d=0000", rd_valid, data_out);
    end
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      tick();
      exp_d = (k >= RD_LAT) ? model[100] : '0;
      checks++;
      if (rd_valid !== (k >= RD_LAT) || data_out !== exp_d) begin
        errors++; $display("FAIL read_timing edge%0d got v=%b d=%h want v=%b d=%h", k, rd_valid, data_out, (k >= RD_LAT), exp_d);
      end
    end
    rd_n = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || data_out !== '0 || dut.r_state !== IDLE) begin
      errors++; $display("FAIL read_end got v=%b d=%h s=%0d want v=0 d=0000 IDLE", rd_valid, data_out, dut.r_state);
    end
    go_idle(1);
  endtask

  task automatic test_write_abort();
    do_write(5, 16'h1111);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = 5; data_in = 16'hBEEF;
    tick();
    wr_n = 1'b1;
    tick();
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL abort_state got %0d want IDLE", dut.r_state); end
    go_idle(WR_LAT + 1);
    checks++;
    if (dut.mem[5] !== model[5]) begin errors++; $display("FAIL abort_wr_n_mem got %h want %h", dut.mem[5], model[5]); end
    // Abort via cs_n exactly on the would-be commit edge.
    cs_n = 1'b0; wr_n = 1'b0; addr = 5; data_in = 16'hBEEF;
    tick();
    repeat (WR_LAT - 1) tick();
    cs_n = 1'b1;
    tick();
    checks++;
    if (dut.mem[5] !== model[5] || dut.r_state !== IDLE) begin
      errors++; $display("FAIL abort_cs_n got mem=%h s=%0d want mem=%h IDLE", dut.mem[5], dut.r_state, model[5]);
    end
    go_idle(1);
  endtask

  task automatic test_rw_priority();
    logic [DATA_W-1:0] old;
    old = dut.mem[7];
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 7; data_in = 16'h00A5;
    tick();
    for (int k = 1; k <= WR_LAT + 2; k++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL prio_rd_valid edge%0d got %b want 0", k, rd_valid); end
      if (k == WR_LAT - 1) begin
        checks++;
        if (dut.mem[7] !== old) begin errors++; $display("FAIL prio_early got %h want %h", dut.mem[7], old); end
      end
    end
    checks++;
    if (dut.mem[7] !== 16'h00A5) begin errors++; $display("FAIL prio_mem got %h want 00a5", dut.mem[7]); end
    model[7] = 16'h00A5;
    go_idle(1);
  endtask

  task automatic test_reset_mid_write();
    do_write(TOP_ADDR, 16'h0F0F);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = TOP_ADDR; data_in = 16'h5555;
    tick();
    repeat (WR_LAT - 1) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || dut.r_state !== IDLE) begin
      errors++; $display("FAIL rst_mid_write_async got v=%b s=%0d want v=0 IDLE", rd_valid, dut.r_state);
    end
    tick();
    tick();
    checks++;
    if (dut.mem[TOP_ADDR] !== model[TOP_ADDR]) begin
      errors++; $display("FAIL rst_mid_write_mem got %h want %h", dut.mem[TOP_ADDR], model[TOP_ADDR]);
    end
    go_idle(0);
    rst_n = 1'b1;
    tick();
    // Top address readable; reset during valid read clears outputs without an edge.
    cs_n = 1'b0; rd_n = 1'b0; addr = TOP_ADDR;
    tick();
    repeat (RD_LAT) tick();
    checks++;
    if (rd_valid !== 1'b1 || data_out !== model[TOP_ADDR]) begin
      errors++; $display("FAIL top_addr_read got v=%b d=%h want v=1 d=%h", rd_valid, data_out, model[TOP_ADDR]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || data_out !== '0 || dut.r_state !== IDLE) begin
      errors++; $display("FAIL rst_mid_read got v=%b d=%h s=%0d want v=0 d=0000 IDLE", rd_valid, data_out, dut.r_state);
    end
    go_idle(0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random_back_to_back();
    logic [ADDR_W-1:0] pool [8];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_d;
    logic              exp_v;
    int                hold;
    pool[0] = '0;
    pool[1] = TOP_ADDR;
    for (int i = 2; i < 8; i++) pool[i] = ADDR_W'($urandom);
    for (int i = 0; i < 8; i++) do_write(pool[i], DATA_W'($urandom));
    for (int op = 0; op < 60; op++) begin
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) begin
        d = DATA_W'($urandom);
        hold = $urandom_range(0, WR_LAT + 2);
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'($urandom_range(0, 1)); addr = a; data_in = d;
        tick();
        addr = ADDR_W'($urandom); data_in = DATA_W'($urandom);
        for (int k = 1; k <= hold + 1; k++) begin
          if (k == hold + 1) begin
            if ($urandom_range(0, 1) == 1) cs_n = 1'b1; else wr_n = 1'b1;
          end
          tick();
          exp_d = (k >= WR_LAT && hold >= WR_LAT) ? d : model[a];
          checks++;
          if (dut.mem[a] !== exp_d || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_write op%0d edge%0d hold%0d got mem=%h v=%b want mem=%h v=0", op, k, hold, dut.mem[a], rd_valid, exp_d);
          end
        end
        if (hold >= WR_LAT) model[a] = d;
      end else begin
        hold = $urandom_range(0, RD_LAT + 2);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = a;
        tick();
        addr = ADDR_W'($urandom);
        for (int k = 1; k <= hold + 1; k++) begin
          if (k == hold + 1) begin
            if ($urandom_range(0, 1) == 1) cs_n = 1'b1; else rd_n = 1'b1;
          end
          tick();
          exp_v = (k <= hold && k >= RD_LAT);
          exp_d = exp_v ? model[a] : '0;
          checks++;
          if (rd_valid !== exp_v || data_out !== exp_d) begin
            errors++; $display("FAIL rnd_read op%0d edge%0d hold%0d got v=%b d=%h want v=%b d=%h", op, k, hold, rd_valid, data_out, exp_v, exp_d);
          end
        end
      end
      checks++;
      if (dut.r_state !== IDLE) begin errors++; $display("FAIL rnd_end_state op%0d got %0d want IDLE", op, dut.r_state); end
      go_idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read_timing();
    test_write_abort();
    test_rw_priority();
    test_reset_mid_write();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
